time_preset_ctrl: RTL and testbench

TIME_PRESET_CTRL -- requirements
Module: time_preset_ctrl

---
 rtl/time_preset_ctrl.sv | 155 +++++++++++++++
 tb/tb_time_preset_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/time_preset_ctrl.sv
// Minutes/seconds preset editor: edge-detected step buttons with hold-to-repeat,
// wrap-around increment/decrement with seconds-to-minutes carry, and a synchronous clear.
module time_preset_ctrl #(
  parameter int W       = 6,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int RPT_DLY = 50000000,
  parameter int RPT_PER = 10000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         btn_sec,
  input  logic         btn_min,
  input  logic         dir,
  input  logic         clr,
  output logic [W-1:0] min_val,
  output logic [W-1:0] sec_val,
  output logic         rpt_active
);

  localparam int CNT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [W-1:0]  SEC_MAX_W = W'(SEC_MAX);
  localparam logic [W-1:0]  MIN_MAX_W = W'(MIN_MAX);
  localparam logic [CW-1:0] DLY_LAST  = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(RPT_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_min_q, act_min_d;
  logic          btn_sec_q, btn_min_q;
  logic          arm_q;
  logic          rpt_q;
  logic [W-1:0]  sec_q, sec_d;
  logic [W-1:0]  min_q, min_d;

  logic          press_sec, press_min, any_press, held, sel_min, step;
  logic [CW-1:0] cnt_last;
  logic [W-1:0]  sec_inc, sec_dec, min_inc, min_dec;
  logic          sec_wrap;

  // arm_q masks the first edge after reset so a button held through reset is
  // absorbed into the sample register instead of being taken as a fresh press.
  assign press_sec = btn_sec & ~btn_sec_q & arm_q;
  assign press_min = btn_min & ~btn_min_q & arm_q;
  assign any_press = press_sec | press_min;
  assign held      = btn_sec | btn_min;
  assign sel_min   = btn_min;
  assign cnt_last  = (state_q == S_HOLD) ? DLY_LAST : PER_LAST;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_min_d = act_min_q;
    step      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mode && any_press) begin
          step      = 1'b1;
          state_d   = S_HOLD;
          cnt_d     = '0;
          act_min_d = sel_min;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!mode || !held) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (any_press && (sel_min != act_min_q)) begin
          // The other button took over: restart the hold sequence for it.
          step      = 1'b1;
          state_d   = S_HOLD;
          cnt_d     = '0;
          act_min_d = sel_min;
        end else begin
          act_min_d = sel_min;
          if (cnt_q == cnt_last) begin
            step    = 1'b1;
            state_d = S_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sec_inc  = (sec_q == SEC_MAX_W) ? '0 : sec_q + W'(1);
  assign sec_dec  = (sec_q == '0) ? SEC_MAX_W : sec_q - W'(1);
  assign min_inc  = (min_q == MIN_MAX_W) ? '0 : min_q + W'(1);
  assign min_dec  = (min_q == '0) ? MIN_MAX_W : min_q - W'(1);
  assign sec_wrap = dir ? (sec_q == '0) : (sec_q == SEC_MAX_W);

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (mode) begin
      if (clr) begin
        sec_d = '0;
        min_d = '0;
      end else if (step) begin
        if (sel_min) begin
          min_d = dir ? min_dec : min_inc;
        end else begin
          sec_d = dir ? sec_dec : sec_inc;
          if (sec_wrap) min_d = dir ? min_dec : min_inc;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      act_min_q <= 1'b0;
      btn_sec_q <= 1'b0;
      btn_min_q <= 1'b0;
      arm_q     <= 1'b0;
      rpt_q     <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_min_q <= act_min_d;
      btn_sec_q <= btn_sec;
      btn_min_q <= btn_min;
      arm_q     <= 1'b1;
      rpt_q     <= (state_d == S_REPEAT);
      sec_q     <= sec_d;
      min_q     <= min_d;
    end
  end

  assign sec_val    = sec_q;
  assign min_val    = min_q;
  assign rpt_active = rpt_q;

endmodule

// File: tb/tb_time_preset_ctrl.sv
// Directed bench for time_preset_ctrl with short repeat timing (RPT_DLY=4, RPT_PER=2).
module tb_time_preset_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, mode, btn_sec, btn_min, dir, clr;
  logic [5:0] min_val, sec_val;
  logic       rpt_active;

  int checks   = 0;
  int failures = 0;

  time_preset_ctrl #(
    .W(6), .SEC_MAX(59), .MIN_MAX(59), .RPT_DLY(4), .RPT_PER(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .btn_sec   (btn_sec),
    .btn_min   (btn_min),
    .dir       (dir),
    .clr       (clr),
    .min_val   (min_val),
    .sec_val   (sec_val),
    .rpt_active(rpt_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse; returns at the negedge after the button is dropped.
  task automatic pulse(input logic s, input logic m);
    btn_sec = s;
    btn_min = m;
    @(negedge clk);
    btn_sec = 1'b0;
    btn_min = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] hold_sec [10];
    logic       hold_rpt [10];
    hold_sec = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd3, 6'd4, 6'd4};
    hold_rpt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; mode = 1'b0; btn_sec = 1'b0; btn_min = 1'b0; dir = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_min", min_val, 0);
    check("reset_sec", sec_val, 0);
    check("reset_rpt", rpt_active, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Decrement wrap of both fields from 0:00.
    mode = 1'b1; dir = 1'b1;
    btn_sec = 1'b1;
    @(negedge clk);
    check("dec_wrap_sec_latency", sec_val, 59);
    check("dec_wrap_min_latency", min_val, 59);
    btn_sec = 1'b0;
    @(negedge clk);

    // Minutes increment wrap 59 -> 0, then up to 5.
    dir = 1'b0;
    pulse(1'b0, 1'b1);
    check("min_inc_wrap", min_val, 0);
    check("min_step_keeps_sec", sec_val, 59);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
    check("min_at_5", min_val, 5);

    // Seconds increment wrap with carry into minutes.
    btn_sec = 1'b1;
    @(negedge clk);
    check("inc_wrap_sec", sec_val, 0);
    check("inc_wrap_carry_min", min_val, 6);
    check("inc_wrap_rpt", rpt_active, 0);
    btn_sec = 1'b0;
    @(negedge clk);
    check("inc_wrap_rpt_after", rpt_active, 0);

    // Hold seconds for 10 cycles: steps at press, +4, +6, +8.
    btn_sec = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_sec_c%0d", i), sec_val, hold_sec[i]);
      check($sformatf("hold_rpt_c%0d", i), rpt_active, hold_rpt[i]);
    end
    btn_sec = 1'b0;
    @(negedge clk);
    check("hold_release_sec", sec_val, 4);
    check("hold_release_rpt", rpt_active, 0);
    check("hold_release_min", min_val, 6);

    // Clear, then build 3:10.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_min", min_val, 0);
    check("clr_sec", sec_val, 0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
    check("setup_min_3", min_val, 3);
    check("setup_sec_10", sec_val, 10);

    // Simultaneous press: minutes step only.
    pulse(1'b1, 1'b1);
    check("both_min", min_val, 4);
    check("both_sec", sec_val, 10);

    // Minutes rising while seconds is held counts as a new press.
    btn_sec = 1'b1;
    repeat (2) @(negedge clk);
    check("takeover_pre_sec", sec_val, 11);
    btn_min = 1'b1;
    @(negedge clk);
    check("takeover_min", min_val, 5);
    check("takeover_sec", sec_val, 11);
    btn_sec = 1'b0; btn_min = 1'b0;
    @(negedge clk);

    // Setup disabled: buttons and clear ignored.
    mode = 1'b0; clr = 1'b1;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("mode0_min_hold", min_val, 5);
    check("mode0_sec_hold", sec_val, 11);
    mode = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("mode1_clr_min", min_val, 0);
    check("mode1_clr_sec", sec_val, 0);

    // Reset while repeating, button still held afterwards.
    btn_sec = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_reset_sec", sec_val, 2);
    check("pre_reset_rpt", rpt_active, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_sec", sec_val, 0);
    check("async_reset_rpt", rpt_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("held_after_reset_sec", sec_val, 0);
    check("held_after_reset_min", min_val, 0);
    check("held_after_reset_rpt", rpt_active, 0);
    btn_sec = 1'b0;
    @(negedge clk);
    btn_sec = 1'b1;
    @(negedge clk);
    check("repress_sec", sec_val, 1);
    btn_sec = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
